block_mem_responder: RTL and testbench

BLOCK_MEM_RESPONDER -- requirements
Module: block_mem_responder

---
 rtl/cache_pkg.sv | 16 +
 rtl/block_mem_responder.sv | 86 ++++++++
 tb/tb_block_mem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory constants and the memory responder state type.
package cache_pkg;

  localparam int WORD_SIZE       = 32;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_SIZE      = WORDS_PER_BLOCK * WORD_SIZE;
  localparam int ADDR_WIDTH      = 32 - $clog2(WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/block_mem_responder.sv
// Fixed-latency block memory servicing cache fills and dirty-block writebacks,
// one request at a time; requests arriving while busy are dropped.
module block_mem_responder #(
  parameter int WORD_SIZE       = cache_pkg::WORD_SIZE,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int MEM_DEPTH       = 256,
  parameter int LATENCY         = 4,
  localparam int BLOCK_SIZE     = WORDS_PER_BLOCK * WORD_SIZE,
  localparam int ADDR_WIDTH     = 32 - $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic [ADDR_WIDTH-1:0] block_addr,
  input  logic [BLOCK_SIZE-1:0] dirty_block_in,
  output logic [BLOCK_SIZE-1:0] data_out_mem,
  output logic                  mem_ready,
  output logic                  mem_busy
);
  import cache_pkg::*;

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  mem_state_t            state;
  logic [3:0]            count;
  logic [IDX_W-1:0]      addr_q;
  logic [BLOCK_SIZE-1:0] wdata_q;
  logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH];

  // Upper address bits alias onto the same entries.
  logic [IDX_W-1:0] idx;
  logic             unused_addr_bits;
  assign idx              = block_addr[IDX_W-1:0];
  assign unused_addr_bits = ^block_addr[ADDR_WIDTH-1:IDX_W];

  // The array has no reset; it only changes on the edge that enters DONE
  // from WR_WAIT, so a reset during WR_WAIT leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_out_mem <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_en_mem) begin
            addr_q  <= idx;
            wdata_q <= dirty_block_in;
            count   <= LAT_LOAD;
            state   <= WR_WAIT;
          end else if (read_en_mem) begin
            addr_q <= idx;
            count  <= LAT_LOAD;
            state  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (count == 4'd0) begin
            data_out_mem <= mem[addr_q];
            state        <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        WR_WAIT: begin
          if (count == 4'd0) begin
            mem[addr_q] <= wdata_q;
            state       <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ready = (state == DONE);
  assign mem_busy  = (state != IDLE);

endmodule

// File: tb/tb_block_mem_responder.sv
// Randomized and directed bench for block_mem_responder against a
// transaction-level model of a fixed-latency, single-outstanding memory.
module tb_block_mem_responder;

  localparam int LAT = 4;
  localparam int AW  = 30;
  localparam int BW  = 128;

  localparam logic [BW-1:0] PRE_10 = 128'hAAAABBBB_CCCC1111_DDDD2222_EEEE3333;
  localparam logic [BW-1:0] PRE_09 = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
  localparam logic [BW-1:0] WR_05  = 128'h11112222_33334444_55556666_77778888;
  localparam logic [BW-1:0] FACE   = 128'hFACEFACE_FACEFACE_FACEFACE_FACEFACE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd  = 1'b0;
  logic          wr  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [BW-1:0] din  = '0;
  logic [BW-1:0] data_out_mem;
  logic          mem_ready;
  logic          mem_busy;

  always #5 clk = ~clk;

  block_mem_responder #(
    .WORD_SIZE(32),
    .WORDS_PER_BLOCK(4),
    .MEM_DEPTH(256),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_en_mem(rd),
    .write_en_mem(wr),
    .block_addr(addr),
    .dirty_block_in(din),
    .data_out_mem(data_out_mem),
    .mem_ready(mem_ready),
    .mem_busy(mem_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: a request seen while nothing is outstanding occupies the memory
  // for LAT+1 cycles; the last of those is the ready cycle, and the
  // read/write takes effect as that cycle begins.
  logic [BW-1:0] mm [256];
  int            rem = 0;
  logic          p_wr;
  logic [7:0]    p_idx;
  logic [BW-1:0] p_data;
  logic [BW-1:0] exp_data = '0;
  bit            model_on = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= 0;
      exp_data <= '0;
    end else if (rem == 0) begin
      if (rd || wr) begin
        rem    <= LAT + 1;
        p_wr   <= wr;
        p_idx  <= addr[7:0];
        p_data <= din;
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) begin
        if (p_wr) mm[p_idx] <= p_data;
        else      exp_data  <= mm[p_idx];
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("ready", {127'b0, mem_ready}, {127'b0, rem == 1});
      check("busy",  {127'b0, mem_busy},  {127'b0, rem != 0});
      check("data",  data_out_mem, exp_data);
    end
  end

  // Called at a negedge; holds the request for one edge, then watches
  // LAT+4 negedges and reports when mem_ready appeared and how often.
  task automatic issue(input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [BW-1:0] d, output int lat, output int pulses);
    rd = r; wr = w; addr = a; din = d;
    lat = -1; pulses = 0;
    @(posedge clk);
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rd = 1'b0; wr = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
      end
      if (mem_ready) begin
        pulses++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  initial begin
    int lat, pulses;
    logic [BW-1:0] v, prev;
    logic [31:0]   r32;

    for (int i = 0; i < 256; i++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      mm[i]     <= v;
      dut.mem[i] <= v;
    end
    mm[8'h10]      <= PRE_10;
    dut.mem[8'h10] <= PRE_10;
    mm[8'h09]      <= PRE_09;
    dut.mem[8'h09] <= PRE_09;

    repeat (2) @(negedge clk);
    model_on = 1'b1;
    check("rst_ready", {127'b0, mem_ready}, '0);
    check("rst_busy",  {127'b0, mem_busy},  '0);
    check("rst_data",  data_out_mem, '0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 1'b0, 30'h010, '0, lat, pulses);
    check("rd10_latency", BW'(lat), BW'(LAT));
    check("rd10_pulses", BW'(pulses), 1);
    check("rd10_data", data_out_mem, PRE_10);

    issue(1'b0, 1'b1, 30'h005, WR_05, lat, pulses);
    check("wr05_latency", BW'(lat), BW'(LAT));
    check("wr05_pulses", BW'(pulses), 1);
    issue(1'b1, 1'b0, 30'h005, '0, lat, pulses);
    check("rd05_pulses", BW'(pulses), 1);
    check("rd05_data", data_out_mem, WR_05);

    prev = data_out_mem;
    issue(1'b1, 1'b1, 30'h007, FACE, lat, pulses);
    check("rw07_pulses", BW'(pulses), 1);
    check("rw07_entry", dut.mem[7], FACE);
    check("rw07_data_held", data_out_mem, prev);

    // Write to 0x30 while a read to 0x20 is held across WR_WAIT and DONE.
    wr = 1'b1; addr = 30'h030; din = {$urandom, $urandom, $urandom, $urandom};
    pulses = 0;
    @(posedge clk);
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (k == 0) wr = 1'b0;
      if (k == 2) begin rd = 1'b1; addr = 30'h020; end
      if (k == LAT + 1) rd = 1'b0;
      if (mem_ready) pulses++;
    end
    check("busy_ignore_pulses", BW'(pulses), 1);
    check("busy_ignore_idle", {127'b0, mem_busy}, '0);

    // Reset two cycles into a write to 0x09.
    wr = 1'b1; addr = 30'h009; din = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", {127'b0, mem_ready}, '0);
    check("midrst_busy",  {127'b0, mem_busy},  '0);
    check("midrst_data",  data_out_mem, '0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_entry09", dut.mem[9], PRE_09);
    issue(1'b1, 1'b0, 30'h009, '0, lat, pulses);
    check("rd09_data", data_out_mem, PRE_09);

    issue(1'b1, 1'b0, 30'h110, '0, lat, pulses);
    check("alias110_data", data_out_mem, PRE_10);

    for (int n = 0; n < 600; n++) begin
      r32 = $urandom;
      if (r32[5:0] == 6'd0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        rd   = r32[8:7] == 2'b00;
        wr   = r32[11:9] == 3'b000;
        addr = {r32[31:20], 14'($urandom), r32[15:12]};
        din  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
    end
    rd = 1'b0; wr = 1'b0;
    repeat (LAT + 3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
